// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus counter-based debounce FSM for a
// raw push-button. Emits a one-cycle `load` strobe per accepted press and a
// registered debounced `level`.
// Optional feature macro: AUTOREPEAT_EN -- when defined, additional `load`
// strobes are generated REPEAT_DELAY cycles after a press and then every
// REPEAT_PERIOD cycles while the button stays held.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic load,
  output logic level
);

  // Reject parameter values the counters cannot honour.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must lie in 2..65535");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HELD    = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        s1_q, s2_q;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        load_q, load_d;
  logic        press_strobe;
  logic        press_accept;
  logic        rpt_fire;

  // Two-flop synchroniser; only s2_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM next-state, stable-sample counter and press strobe.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    press_strobe = 1'b0;
    press_accept = 1'b0;
    cnt_d        = (s2_q != level_q) ? cnt_q + 16'd1 : '0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = HELD;
          level_d      = 1'b1;
          press_strobe = 1'b1;
          press_accept = 1'b1;
          cnt_d        = '0;
        end
      end
      HELD: begin
        if (!s2_q) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
    load_d = press_strobe | rpt_fire;
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      load_q  <= load_d;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_nxt;
  logic             rpt_first_q, rpt_first_d;

  // Repeat timer: advances only on HELD cycles where the button is still
  // high, so a release attempt in progress neither counts nor fires; it
  // freezes through WAIT_LO and is cleared in IDLE and on each new press.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    rpt_nxt     = rpt_q + 1'b1;
    if (press_accept || state_q == IDLE) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == HELD && s2_q) begin
      if (rpt_nxt == (rpt_first_q ? RPT_DELAY_V : RPT_PERIOD_V)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_nxt;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign load  = load_q;
  assign level = level_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed scenarios plus randomized button
// activity, checked by a scoreboard fed from a behavioural reference model.
module tb_btn_debounce;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic load;
  logic level;

  always #5 clk = ~clk;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_in),
    .load  (load),
    .level (level)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int strobes = 0;
  int pushes  = 0;
  int exp_q[$];
  int obs_q[$];

  // Reference model: pad delayed by two samples, then a run-length rule --
  // D consecutive samples disagreeing with the level flip it; a rising
  // flip is a press. Auto-repeat counts held cycles with no release pending.
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_first = 1'b1;
  int m_run = 0, m_hold = 0;

  task automatic model_clear();
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
    m_run = 0; m_hold = 0; m_first = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_exp();
    exp_q.push_back(cyc);
    pushes++;
  endtask

  task automatic model_step();
    bit s;
    s = m_s2;
`ifdef AUTOREPEAT_EN
    if (m_lvl && m_run == 0 && s) begin
      m_hold++;
      if (m_hold == int'(m_first ? RD : RP)) begin
        push_exp();
        m_hold  = 0;
        m_first = 1'b0;
      end
    end
`endif
    if (s != m_lvl) begin
      m_run++;
      if (m_run == int'(D)) begin
        m_lvl = s;
        m_run = 0;
        if (s) begin
          push_exp();
          m_hold  = 0;
          m_first = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    cyc++;
    if (rst_n) model_step();
  end

  // Monitor: pops expected strobes whenever the DUT strobes, checks level.
  always begin
    int e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      checks++;
      if (load !== 1'b0 || level !== 1'b0) begin
        errors++;
        $display("FAIL reset_out cyc %0d: load=%b level=%b, required 0/0", cyc, load, level);
      end
    end else begin
      if (load === 1'b1) begin
        strobes++;
        obs_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load at cyc %0d: no strobe expected", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != cyc) begin
            errors++;
            $display("FAIL load_cycle: got strobe at %0d, required %0d", cyc, e);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missed_load: no strobe at %0d, required at %0d", cyc, e);
      end
      checks++;
      if (level !== m_lvl) begin
        errors++;
        $display("FAIL level cyc %0d: got %b, required %b", cyc, level, m_lvl);
      end
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      btn_in = v;
    end
  endtask

  task automatic check_int(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic wait_load(input string nm, input int req);
    int found;
    found = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (load === 1'b1) begin
        found = cyc;
        break;
      end
    end
    check_int(nm, found, req);
  endtask

  task automatic wait_fall(input string nm, input int req);
    int found;
    found = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (level === 1'b0) begin
        found = cyc;
        break;
      end
    end
    check_int(nm, found, req);
  endtask

  function automatic int plain_or_model(input int plain, input int model_delta);
`ifdef AUTOREPEAT_EN
    return model_delta;
`else
    return (model_delta >= 0) ? plain : plain;
`endif
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s0, p0, v, n;
    btn_in = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 6);

    // Clean press held 20 cycles.
    s0 = strobes; p0 = pushes;
    @(negedge clk); btn_in = 1'b1; k = cyc + 1;
    wait_load("clean_latency", k + 5);
    drive(1, 14);
    drive(0, 12);
    check_int("clean_count", strobes - s0, plain_or_model(1, pushes - p0));

    // Bounce then settle high.
    s0 = strobes; p0 = pushes;
    drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1);
    @(negedge clk); btn_in = 1'b1; k = cyc + 1;
    wait_load("bounce_latency", k + 5);
    drive(1, 14);
    drive(0, 12);
    check_int("bounce_count", strobes - s0, plain_or_model(1, pushes - p0));

    // Short glitch.
    s0 = strobes;
    drive(1, 3);
    drive(0, 10);
    check_int("glitch_count", strobes - s0, 0);
    check_int("glitch_level", int'(level), 0);

    // Release bounce, then clean release.
    s0 = strobes; p0 = pushes;
    @(negedge clk); btn_in = 1'b1; k = cyc + 1;
    wait_load("rb_press_latency", k + 5);
    drive(1, 5); drive(0, 2); drive(1, 6);
    check_int("rb_level_held", int'(level), 1);
    @(negedge clk); btn_in = 1'b0; k = cyc + 1;
    wait_fall("release_latency", k + 5);
    drive(0, 8);
    check_int("rb_count", strobes - s0, plain_or_model(1, pushes - p0));

    // Reset mid-count in WAIT_HI (counter = 2).
    s0 = strobes;
    @(negedge clk); btn_in = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_int("rst_wait_level", int'(level), 0);
    check_int("rst_wait_load", int'(load), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; k = cyc + 1;
    wait_load("post_reset_latency", k + 5);
    check_int("post_reset_count", strobes - s0, 1);
    // Reset while HELD must drop level without waiting for a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_int("rst_held_level", int'(level), 0);
    check_int("rst_held_load", int'(load), 0);
    @(negedge clk); btn_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    drive(0, 8);

`ifdef AUTOREPEAT_EN
    // Held 30 cycles: press at P, repeats at P+8, then every 3 cycles.
    s0 = obs_q.size();
    @(negedge clk); btn_in = 1'b1; k = cyc + 1;
    drive(1, 29);
    drive(0, 12);
    check_int("ar_count", obs_q.size() - s0, 8);
    if (obs_q.size() - s0 == 8) begin
      check_int("ar_press", obs_q[s0], k + 5);
      for (int i = 0; i < 7; i++)
        check_int("ar_repeat", obs_q[s0 + 1 + i], k + 5 + int'(RD) + i * int'(RP));
    end
`endif

    // Randomized button activity with occasional asynchronous resets.
    for (int i = 0; i < 150; i++) begin
      v = int'($urandom_range(0, 1));
      n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(5, 16)) : int'($urandom_range(1, 5));
      drive(v[0], n);
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    drive(0, 20);

    check_int("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
